// File: rtl/sel_split_n.sv
// sel_split_n: routes one-cycle upstream requests to one of N credit-managed
// downstream channels, then acknowledges upstream FREE_DELAY cycles after the
// downstream drive pulse. Protocol violations raise a sticky error flag.
module sel_split_n #(
    parameter int N          = 3,
    parameter int CREDITS    = 1,
    parameter int FREE_DELAY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_drive,
    input  logic [N-1:0] i_sel,
    input  logic [N-1:0] i_freeNext,
    output logic         o_free,
    output logic [N-1:0] o_driveNext,
    output logic         o_busy,
    output logic         o_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int DW = $clog2(FREE_DELAY + 1);

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);
    localparam logic [DW-1:0] DLY_ZERO = DW'(0);
    localparam logic [DW-1:0] DLY_ONE  = DW'(1);
    // Cycle in which the o_free pulse is launched (it appears one cycle later).
    localparam logic [DW-1:0] DLY_FIRE = DW'(FREE_DELAY - 1);
    // Cycle in which o_free is visible; the FSM leaves DELAY after it.
    localparam logic [DW-1:0] DLY_LAST = DW'(FREE_DELAY);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_CREDIT = 2'd1,
        DELAY       = 2'd2
    } state_t;

    state_t         state_r;
    state_t         nextState_s;
    logic [N-1:0]   selLatch_r;
    logic [N-1:0]   selNext_s;
    logic [DW-1:0]  delayCnt_r;
    logic [DW-1:0]  delayNext_s;
    logic [CW-1:0]  credCnt_r  [N];
    logic [CW-1:0]  credNext_s [N];
    logic [N-1:0]   credNz_s;
    logic [N-1:0]   credOvf_s;
    logic [N-1:0]   consumeVec_s;
    logic [N-1:0]   driveNext_s;
    logic           freePulse_s;
    logic           protoErr_s;

    logic [N-1:0]   driveNext_r;
    logic           free_r;
    logic           busy_r;
    logic           err_r;

    // True when exactly one bit of the select vector is set.
    function automatic logic isOneHot(input logic [N-1:0] v);
        logic [N-1:0] vMinusOne;
        vMinusOne = v - {{(N-1){1'b0}}, 1'b1};
        return (v != {N{1'b0}}) && ((v & vMinusOne) == {N{1'b0}});
    endfunction

    // Per-channel "has at least one credit" flags.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            credNz_s[k] = (credCnt_r[k] != {CW{1'b0}});
        end
    end

    // FSM next-state, channel consume and output-pulse decisions.
    always_comb begin
        nextState_s  = state_r;
        selNext_s    = selLatch_r;
        delayNext_s  = delayCnt_r;
        consumeVec_s = {N{1'b0}};
        driveNext_s  = {N{1'b0}};
        freePulse_s  = 1'b0;
        protoErr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_drive) begin
                    if (isOneHot(i_sel)) begin
                        selNext_s = i_sel;
                        if ((i_sel & credNz_s) != {N{1'b0}}) begin
                            driveNext_s  = i_sel;
                            consumeVec_s = i_sel;
                            delayNext_s  = DLY_ZERO;
                            nextState_s  = DELAY;
                        end else begin
                            nextState_s = WAIT_CREDIT;
                        end
                    end else begin
                        // Malformed select: acknowledge and drop it.
                        protoErr_s  = 1'b1;
                        freePulse_s = 1'b1;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            WAIT_CREDIT: begin
                if (i_drive) begin
                    protoErr_s = 1'b1;
                end else begin
                    protoErr_s = 1'b0;
                end
                // A credit returned this very cycle is usable immediately.
                if ((selLatch_r & (credNz_s | i_freeNext)) != {N{1'b0}}) begin
                    driveNext_s  = selLatch_r;
                    consumeVec_s = selLatch_r;
                    delayNext_s  = DLY_ZERO;
                    nextState_s  = DELAY;
                end else begin
                    nextState_s = WAIT_CREDIT;
                end
            end
            DELAY: begin
                if (i_drive) begin
                    protoErr_s = 1'b1;
                end else begin
                    protoErr_s = 1'b0;
                end
                if (delayCnt_r == DLY_LAST) begin
                    // o_free is visible now; the next cycle accepts a request.
                    nextState_s = IDLE;
                    delayNext_s = DLY_ZERO;
                    selNext_s   = {N{1'b0}};
                end else begin
                    delayNext_s = delayCnt_r + DLY_ONE;
                    if (delayCnt_r == DLY_FIRE) begin
                        freePulse_s = 1'b1;
                    end else begin
                        freePulse_s = 1'b0;
                    end
                end
            end
            default: begin
                nextState_s = IDLE;
                selNext_s   = {N{1'b0}};
                delayNext_s = DLY_ZERO;
            end
        endcase
    end

    // Credit arithmetic: a return and a consume in the same cycle cancel out.
    always_comb begin
        credOvf_s = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            credNext_s[k] = credCnt_r[k];
            if (consumeVec_s[k] && !i_freeNext[k]) begin
                credNext_s[k] = credCnt_r[k] - CRED_ONE;
            end else if (i_freeNext[k] && !consumeVec_s[k]) begin
                if (credCnt_r[k] == CRED_MAX) begin
                    credOvf_s[k] = 1'b1;
                end else begin
                    credNext_s[k] = credCnt_r[k] + CRED_ONE;
                end
            end else begin
                credNext_s[k] = credCnt_r[k];
            end
        end
    end

    // FSM state, latched channel select and delay counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            selLatch_r <= {N{1'b0}};
            delayCnt_r <= DLY_ZERO;
        end else begin
            state_r    <= nextState_s;
            selLatch_r <= selNext_s;
            delayCnt_r <= delayNext_s;
        end
    end

    // Per-channel credit counters, refilled to the maximum on reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                credCnt_r[k] <= CRED_MAX;
            end else begin
                credCnt_r[k] <= credNext_s[k];
            end
        end
    end

    // Registered outputs; the error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            driveNext_r <= {N{1'b0}};
            free_r      <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            driveNext_r <= driveNext_s;
            free_r      <= freePulse_s;
            busy_r      <= (nextState_s != IDLE);
            err_r       <= err_r | protoErr_s | (|credOvf_s);
        end
    end

    assign o_driveNext = driveNext_r;
    assign o_free      = free_r;
    assign o_busy      = busy_r;
    assign o_err       = err_r;

endmodule

// File: tb/tb_sel_split_n.sv
// Directed scoreboard bench for sel_split_n: one instance with default
// parameters (A) and one with N=4, CREDITS=3 (B). Each step drives one
// cycle of inputs, queues the expected outputs for the following cycle and
// checks them just after the clock edge.
module tb_sel_split_n;

    logic       clk = 1'b0;
    logic       rstA = 1'b1;
    logic       dA = 1'b0;
    logic [2:0] selA = 3'b000;
    logic [2:0] frA = 3'b000;
    logic       oFreeA;
    logic [2:0] oDrvA;
    logic       oBusyA;
    logic       oErrA;

    logic       rstB = 1'b1;
    logic       dB = 1'b0;
    logic [3:0] selB = 4'b0000;
    logic [3:0] frB = 4'b0000;
    logic       oFreeB;
    logic [3:0] oDrvB;
    logic       oBusyB;
    logic       oErrB;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       useB;
        logic [6:0] vec;
        string      tag;
    } exp_t;

    exp_t sbq[$];

    sel_split_n dutA (
        .clk         (clk),
        .rst         (rstA),
        .i_drive     (dA),
        .i_sel       (selA),
        .i_freeNext  (frA),
        .o_free      (oFreeA),
        .o_driveNext (oDrvA),
        .o_busy      (oBusyA),
        .o_err       (oErrA)
    );

    sel_split_n #(.N(4), .CREDITS(3), .FREE_DELAY(2)) dutB (
        .clk         (clk),
        .rst         (rstB),
        .i_drive     (dB),
        .i_sel       (selB),
        .i_freeNext  (frB),
        .o_free      (oFreeB),
        .o_driveNext (oDrvB),
        .o_busy      (oBusyB),
        .o_err       (oErrB)
    );

    always #5 clk = ~clk;

    // Expected output vector: {o_free, o_driveNext (4b), o_busy, o_err}.
    function automatic logic [6:0] ev(input logic fr, input logic [3:0] dv,
                                      input logic bz, input logic er);
        return {fr, dv, bz, er};
    endfunction

    task automatic step(input logic useB, input logic r, input logic d,
                        input logic [3:0] s, input logic [3:0] f,
                        input logic [6:0] expVec, input string tag);
        exp_t e;
        logic [6:0] obs;
        if (useB) begin
            rstB = r; dB = d; selB = s; frB = f;
        end else begin
            rstA = r; dA = d; selA = s[2:0]; frA = f[2:0];
        end
        e.useB = useB;
        e.vec  = expVec;
        e.tag  = tag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        if (e.useB) begin
            obs = {oFreeB, oDrvB, oBusyB, oErrB};
        end else begin
            obs = {oFreeA, 1'b0, oDrvA, oBusyA, oErrA};
        end
        vectors++;
        assert (obs === e.vec) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
        end
    endtask

    task automatic stepA(input logic r, input logic d, input logic [2:0] s,
                         input logic [2:0] f, input logic fr, input logic [2:0] dv,
                         input logic bz, input logic er, input string tag);
        step(1'b0, r, d, {1'b0, s}, {1'b0, f}, ev(fr, {1'b0, dv}, bz, er), tag);
    endtask

    task automatic stepB(input logic r, input logic d, input logic [3:0] s,
                         input logic [3:0] f, input logic fr, input logic [3:0] dv,
                         input logic bz, input logic er, input string tag);
        step(1'b1, r, d, s, f, ev(fr, dv, bz, er), tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- instance A: N=3, CREDITS=1, FREE_DELAY=2 ----------
        //     rst   drv   sel     free    oFree drv     busy  err
        stepA(1'b1, 1'b1, 3'b010, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, "A_rst_in_ignored");
        stepA(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "A_rst_hold");
        // Basic transaction on ch1: drive at t+1, free at t+3, busy t+1..t+3.
        stepA(1'b0, 1'b1, 3'b010, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0, "A_t1_drive");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, "A_t2_busy");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0, "A_t3_free");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "A_t4_idle");
        // Second ch1 request with no credit: waits until a credit returns.
        stepA(1'b0, 1'b1, 3'b010, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, "A_wait_enter");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, "A_wait_hold");
        stepA(1'b0, 1'b0, 3'b000, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0, "A_wait_credit_drive");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, "A_wait_delay");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0, "A_wait_free");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "A_wait_idle");
        stepA(1'b0, 1'b0, 3'b000, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, "A_return_no_err");
        // Request while busy: flagged and ignored, in-flight one completes.
        stepA(1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, "A_busy_drive0");
        stepA(1'b0, 1'b1, 3'b100, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1, "A_busy_req_err");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1, "A_busy_free");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, "A_busy_idle");
        stepA(1'b0, 1'b1, 3'b100, 3'b000, 1'b0, 3'b100, 1'b1, 1'b1, "A_ch2_credit_kept");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1, "A_ch2_delay");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1, "A_ch2_free");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, "A_ch2_idle");
        stepA(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "A_rst_clears_err");
        // Zero and multi-hot selects: no drive, free next cycle, error.
        stepA(1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, "A_sel_zero");
        stepA(1'b0, 1'b1, 3'b101, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, "A_sel_multi");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, "A_sel_after");
        stepA(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "A_rst2");
        // Credit return at full credit: error, counter saturates at 1.
        stepA(1'b0, 1'b0, 3'b000, 3'b001, 1'b0, 3'b000, 1'b0, 1'b1, "A_ovf_err");
        stepA(1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 1'b1, "A_ovf_drive");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1, "A_ovf_delay");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1, "A_ovf_free");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, "A_ovf_idle");
        stepA(1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1, "A_sat_wait");
        stepA(1'b0, 1'b0, 3'b000, 3'b001, 1'b0, 3'b001, 1'b1, 1'b1, "A_sat_drive");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1, "A_sat_delay");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1, "A_sat_free");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, "A_sat_idle");
        stepA(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "A_rst3");
        // Consume and return on ch2 in the same cycle: no error, net unchanged.
        stepA(1'b0, 1'b1, 3'b100, 3'b100, 1'b0, 3'b100, 1'b1, 1'b0, "A_net_drive");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, "A_net_delay");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0, "A_net_free");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "A_net_idle");
        stepA(1'b0, 1'b1, 3'b100, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0, "A_net_credit_kept");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, "A_net2_delay");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0, "A_net2_free");
        stepA(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "A_net2_idle");
        stepA(1'b0, 1'b0, 3'b000, 3'b100, 1'b0, 3'b000, 1'b0, 1'b0, "A_net2_return");

        // ---------------- instance B: N=4, CREDITS=3, FREE_DELAY=2 ----------
        stepB(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "B_rst");
        for (int i = 0; i < 3; i++) begin
            stepB(1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0, "B_ch3_drive");
            stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "B_ch3_delay");
            stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, "B_ch3_free");
            stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "B_ch3_idle");
        end
        stepB(1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "B_fourth_waits");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "B_fourth_hold");
        stepB(1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0, "B_fourth_drive");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "B_fourth_delay");
        // Reset in DELAY: the pending free pulse must never appear.
        stepB(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "B_rst_in_delay");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "B_no_free_after_rst");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "B_quiet_after_rst");
        // ch3 back at 3 credits: one more return overflows.
        stepB(1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, "B_ch3_full_after_rst");
        stepB(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "B_rst2");
        // Consume ch0 and ch1, then return both in one cycle: no error.
        stepB(1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "B_ch0_drive");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "B_ch0_delay");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, "B_ch0_free");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "B_ch0_idle");
        stepB(1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, "B_ch1_drive");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "B_ch1_delay");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, "B_ch1_free");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "B_ch1_idle");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, "B_multi_return");
        stepB(1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, "B_ch0_full_again");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sel_split_n.md
SEL_SPLIT_N -- requirements
Module: sel_split_n

Interface
REQ-001 Parameter N, default 3: number of downstream channels, legal range 2..16.
REQ-002 Parameter CREDITS, default 1: maximum outstanding tokens per channel, legal range 1..15.
REQ-003 Parameter FREE_DELAY, default 2: cycles from downstream drive pulse to upstream free pulse, legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 i_drive  in  1  one-cycle upstream request pulse.
REQ-007 i_sel  in  N  channel select, one-hot, sampled only in the cycle i_drive=1.
REQ-008 i_freeNext  in  N  per-channel one-cycle credit-return pulses from downstream.
REQ-009 o_free  out  1  one-cycle pulse acknowledging the upstream request.
REQ-010 o_driveNext  out  N  per-channel one-cycle drive pulses, at most one bit set per cycle.
REQ-011 o_busy  out  1  high whenever the FSM is not in IDLE.
REQ-012 o_err  out  1  sticky protocol-error flag.

Function
REQ-013 FSM states: IDLE, WAIT_CREDIT, DELAY.
REQ-014 Each channel k SHALL hold a credit counter cred[k], width clog2(CREDITS+1), range 0..CREDITS.
REQ-015 IDLE, i_drive=1, i_sel one-hot (channel k), cred[k]>0: latch k, pulse o_driveNext[k] next cycle, decrement cred[k], go DELAY.
REQ-016 IDLE, i_drive=1, i_sel one-hot (channel k), cred[k]=0: latch k, go WAIT_CREDIT, no output pulse.
REQ-017 IDLE, i_drive=1, i_sel zero or multi-hot: set o_err, drive nothing, pulse o_free next cycle, stay IDLE.
REQ-018 WAIT_CREDIT, cred[k]>0, including credit returned in the current cycle: pulse o_driveNext[k] next cycle, decrement cred[k], go DELAY.
REQ-019 DELAY: count FREE_DELAY cycles from the o_driveNext pulse, then pulse o_free once and return to IDLE.
REQ-020 Latency, credit available: i_drive at cycle t gives o_driveNext[k] at t+1 and o_free at t+1+FREE_DELAY.
REQ-021 o_busy SHALL be high from cycle t+1 through the o_free cycle inclusive; a new i_drive is accepted in the cycle after o_free.
REQ-022 i_drive while o_busy=1: set o_err; request ignored; in-flight transaction unaffected.
REQ-023 i_freeNext[k]=1: increment cred[k]; if cred[k]=CREDITS with no same-cycle consume, saturate and set o_err.
REQ-024 i_freeNext[k] in the same cycle as a consume of channel k: net cred[k] unchanged, no error.
REQ-025 Credit returns on all channels are processed in every state, and all channels may return credit simultaneously.
REQ-026 o_driveNext and o_free are registered outputs and are never high in the same cycle.
REQ-027 o_err remains set until rst.

Reset
REQ-028 rst=1 at clock edge: FSM to IDLE, every cred[k]=CREDITS, delay counter 0, latched select 0.
REQ-029 During and after reset: o_free=0, o_driveNext=0, o_busy=0, o_err=0.
REQ-030 Reset mid-transaction SHALL abort with no pending o_driveNext or o_free pulse emitted afterwards.
REQ-031 Inputs in the reset cycle are ignored.

Verification
REQ-032 Defaults; i_drive, i_sel=3'b010 at t -> o_driveNext=3'b010 at t+1, o_free at t+3, cred[1]=0, o_busy high t+1..t+3.
REQ-033 Defaults; two transactions to ch1 without i_freeNext[1] -> second enters WAIT_CREDIT; i_freeNext[1] at t2 -> o_driveNext[1] at t2+1, o_free at t2+3.
REQ-034 i_drive with i_sel=3'b000, then 3'b101 -> no o_driveNext, o_free one cycle after each, o_err=1.
REQ-035 i_freeNext[0] at reset-default credit -> o_err=1, cred[0] stays 1; i_freeNext[2] with a consume of ch2 in the same cycle -> no error.
REQ-036 N=4, CREDITS=3: three drives to ch3 accepted back-to-back per handshake, fourth waits; rst during DELAY -> no o_free, all cred=3, o_err=0.
